alu_pipe: RTL



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core.sv | 84 ++++++++
 rtl/alu_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined ALU.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_ACC  = 3'b101;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational shared arithmetic/logic unit.
// ADD, SUB and the accumulate step all use one main adder through operand muxing.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter bit          ACC_EN = 1'b1
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] next_acc
);

    logic [OP_W-1:0]  eff_op;
    logic [WIDTH-1:0] inner_sum;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             arith;
    logic [WIDTH:0]   sum;

    // Operand steering, shared adder, result select and flags.
    always_comb begin
        eff_op = op;
        if (ACC_EN == 1'b0) begin
            // Without an accumulator, ACC degrades to ADD and CLR to PASS.
            if (op == OP_ACC) eff_op = OP_ADD;
            if (op == OP_CLR) eff_op = OP_PASS;
        end

        // Inner x+y for ACC is truncated before being added to acc.
        inner_sum = x + y;

        add_a   = x;
        add_b   = y;
        add_cin = 1'b0;
        arith   = 1'b0;
        case (eff_op)
            OP_ADD: arith = 1'b1;
            OP_SUB: begin
                add_b   = ~y;
                add_cin = 1'b1;
                arith   = 1'b1;
            end
            OP_ACC: begin
                add_a = acc;
                add_b = inner_sum;
                arith = 1'b1;
            end
            default: arith = 1'b0;
        endcase

        sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

        result   = '0;
        next_acc = acc;
        case (eff_op)
            OP_ADD, OP_SUB: result = sum[WIDTH-1:0];
            OP_AND:         result = x & y;
            OP_OR:          result = x | y;
            OP_XOR:         result = x ^ y;
            OP_ACC: begin
                result   = sum[WIDTH-1:0];
                next_acc = sum[WIDTH-1:0];
            end
            OP_CLR: begin
                result   = '0;
                next_acc = '0;
            end
            OP_PASS:        result = x;
            default:        result = '0;
        endcase

        cout = arith & sum[WIDTH];
        ovf  = arith & (add_a[WIDTH-1] == add_b[WIDTH-1])
                     & (sum[WIDTH-1] != add_a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with operand-pair select, accumulator and
// valid/ready handshakes on both sides.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter bit          ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH-1:0] x_sel, y_sel;
    logic [WIDTH-1:0] x1_q, y1_q;
    logic [OP_W-1:0]  op1_q;
    logic             v1_q, v2_q;
    logic [WIDTH-1:0] y_q, acc_q;
    logic             cout_q, ovf_q, zero_q;
    logic             adv;
    logic [WIDTH-1:0] core_result, core_next_acc;
    logic             core_cout, core_ovf;

    // Pair select happens ahead of the single shared unit.
    assign x_sel = s ? c : a;
    assign y_sel = s ? d : b;

    // Both stages advance together whenever the output slot is free or draining.
    assign adv      = !v2_q || out_ready;
    assign in_ready = !v1_q || adv;

    alu_core #(
        .WIDTH  (WIDTH),
        .ACC_EN (ACC_EN)
    ) u_core (
        .x        (x1_q),
        .y        (y1_q),
        .op       (op1_q),
        .acc      (acc_q),
        .result   (core_result),
        .cout     (core_cout),
        .ovf      (core_ovf),
        .next_acc (core_next_acc)
    );

    // Stage 1: capture the selected operands and opcode on an input transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            x1_q  <= '0;
            y1_q  <= '0;
            op1_q <= OP_ADD;
        end else if (in_valid && in_ready) begin
            v1_q  <= 1'b1;
            x1_q  <= x_sel;
            y1_q  <= y_sel;
            op1_q <= op;
        end else if (adv) begin
            v1_q <= 1'b0;
        end
    end

    // Stage 2: register result and flags; acc moves with the op entering this stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q   <= 1'b0;
            y_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
            acc_q  <= '0;
        end else if (adv) begin
            v2_q <= v1_q;
            if (v1_q) begin
                y_q    <= core_result;
                cout_q <= core_cout;
                ovf_q  <= core_ovf;
                zero_q <= (core_result == '0);
                acc_q  <= core_next_acc;
            end
        end
    end

    assign out_valid = v2_q;
    assign y         = y_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
